// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'h80;
    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned CNT_BITS  = 4;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StStart   = 4'd1,
        StSync    = 4'd2,
        StCheck   = 4'd3,
        StRecv    = 4'd4,
        StStore   = 4'd5,
        StEopWait = 4'd6,
        StErrWait = 4'd7,
        StErrIdle = 4'd8
    } rcu_state_t;

endpackage

// File: rtl/usb_rx_rcu_if.sv
// Signals between the line-side receive blocks (master) and the receive control unit (slave).
interface usb_rx_rcu_if;

    logic       d_edge;
    logic       eop;
    logic       en_sample;
    logic [7:0] rcv_data;
    logic       timer_clear;
    logic       rcving;
    logic       w_enable;
    logic       r_error;

    modport master (
        output d_edge, eop, en_sample, rcv_data,
        input  timer_clear, rcving, w_enable, r_error
    );

    modport slave (
        input  d_edge, eop, en_sample, rcv_data,
        output timer_clear, rcving, w_enable, r_error
    );

endinterface

// File: rtl/flex_counter.sv
// Counter over 0..rollover_val-1; rollover_flag marks the last value so callers can gate it.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk_i,
    input  logic                    n_rst_i,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_out_o,
    output logic                    rollover_flag_o
);

    localparam logic [NUM_CNT_BITS-1:0] One = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    assign rollover_flag_o = (count_q == (rollover_val_i - One));
    assign count_out_o     = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            count_d = rollover_flag_o ? '0 : (count_q + One);
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/usb_rx_rcu.sv
// Receive control unit: sequences the sample timer, frames bytes, checks SYNC and commits data.
import usb_rx_pkg::*;

module usb_rx_rcu (
    input  logic          clk_i,
    input  logic          n_rst_i,
    usb_rx_rcu_if.slave   bus
);

    localparam logic [CNT_BITS-1:0] ByteBitsCnt = CNT_BITS'(BYTE_BITS);

    rcu_state_t          state_q, state_d;
    logic [CNT_BITS-1:0] bit_cnt;
    logic                cnt_last;
    logic                cnt_clear;
    logic                cnt_en;
    logic                byte_done;
    logic                eop_seen_q, eop_seen_d;
    logic                timer_clear_q;
    logic                rcving_q;
    logic                w_enable_q;
    logic                r_error_q;

    assign cnt_clear = (state_q == StStart) || (state_q == StStore);
    assign cnt_en    = bus.en_sample && ((state_q == StSync) || (state_q == StRecv));
    assign byte_done = bus.en_sample && cnt_last;

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_bit_cnt (
        .clk_i           (clk_i),
        .n_rst_i         (n_rst_i),
        .clear_i         (cnt_clear),
        .count_enable_i  (cnt_en),
        .rollover_val_i  (ByteBitsCnt),
        .count_out_o     (bit_cnt),
        .rollover_flag_o (cnt_last)
    );

    // An error entered via SE0 already counts as having seen EOP; a bad SYNC must wait for it.
    assign eop_seen_d = (state_q == StErrWait) ? (eop_seen_q || bus.eop) : bus.eop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.d_edge) state_d = StStart;
            StStart:   state_d = StSync;
            StSync: begin
                if (bus.en_sample && bus.eop) begin
                    state_d = StErrWait;
                end else if (byte_done) begin
                    state_d = StCheck;
                end
            end
            StCheck:   state_d = (bus.rcv_data == SYNC_BYTE) ? StRecv : StErrWait;
            StRecv: begin
                if (bus.en_sample && bus.eop) begin
                    state_d = (bit_cnt == '0) ? StEopWait : StErrWait;
                end else if (byte_done) begin
                    state_d = StStore;
                end
            end
            StStore:   state_d = StRecv;
            StEopWait: if (bus.d_edge && !bus.eop) state_d = StIdle;
            StErrWait: if (bus.d_edge && !bus.eop && eop_seen_q) state_d = StErrIdle;
            StErrIdle: if (bus.d_edge) state_d = StStart;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q       <= StIdle;
            eop_seen_q    <= 1'b0;
            timer_clear_q <= 1'b0;
            rcving_q      <= 1'b0;
            w_enable_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            eop_seen_q    <= eop_seen_d;
            timer_clear_q <= (state_d == StStart);
            rcving_q      <= (state_d != StIdle) && (state_d != StErrIdle);
            w_enable_q    <= (state_d == StStore);
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_error_q <= 1'b0;
        end else if (state_d == StStart) begin
            r_error_q <= 1'b0;
        end else if (state_d == StErrWait) begin
            r_error_q <= 1'b1;
        end
    end

    assign bus.timer_clear = timer_clear_q;
    assign bus.rcving      = rcving_q;
    assign bus.w_enable    = w_enable_q;
    assign bus.r_error     = r_error_q;

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Packet-level bench for usb_rx_rcu: directed and random packets against a byte-level model.
module tb_usb_rx_rcu;

    localparam logic [7:0] Sync = 8'h80;

    logic clk;
    logic n_rst;
    int   total;
    int   bad;

    logic [7:0] pkt_q[$];
    logic [7:0] wq[$];

    usb_rx_rcu_if bus ();

    usb_rx_rcu dut (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write strobe seen mid-cycle records the byte it carried.
    always @(negedge clk) begin
        if (n_rst && bus.w_enable) wq.push_back(bus.rcv_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n, input bit edges);
        for (int i = 0; i < n; i++) begin
            bus.d_edge = edges && ($urandom_range(0, 5) == 0);
            tick();
        end
        bus.d_edge = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        bus.en_sample = 1'b1;
        bus.rcv_data  = {b, bus.rcv_data[7:1]};
        tick();
        bus.en_sample = 1'b0;
    endtask

    // Sends d_edge, the bytes of pkt_q LSB-first, k extra bits, then SE0 and a J edge.
    task automatic send_packet(input int k, input int per);
        bit         sync_ok;
        bit         exp_err;
        logic [7:0] expq[$];
        logic [7:0] b;
        int         n;

        sync_ok = (pkt_q.size() > 0) && (pkt_q[0] == Sync);
        exp_err = !sync_ok || (k != 0);
        expq.delete();
        if (sync_ok) begin
            for (int i = 1; i < pkt_q.size(); i++) expq.push_back(pkt_q[i]);
        end
        wq.delete();

        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
        check("tclr_start", bus.timer_clear, 1);
        check("rcving_start", bus.rcving, 1);
        check("rerr_start", bus.r_error, 0);
        tick();
        check("tclr_single", bus.timer_clear, 0);

        for (int idx = 0; idx < pkt_q.size(); idx++) begin
            b = pkt_q[idx];
            for (int j = 0; j < 8; j++) begin
                idle(per - 1, 1'b1);
                drive_bit(b[j]);
            end
            if (idx == 0) begin
                check("we_sync", bus.w_enable, 0);
                check("rerr_in_check", bus.r_error, 0);
                tick();
                check("rerr_after_check", bus.r_error, !sync_ok);
            end else begin
                check("we_pulse", bus.w_enable, sync_ok);
                if (sync_ok) check("we_data", bus.rcv_data, b);
                tick();
                check("we_single", bus.w_enable, 0);
            end
        end
        for (int j = 0; j < k; j++) begin
            idle(per - 1, 1'b1);
            drive_bit(1'($urandom_range(0, 1)));
        end

        bus.eop = 1'b1;
        for (int j = 0; j < 2; j++) begin
            idle(per - 1, 1'b0);
            drive_bit(1'b0);
        end
        idle(2, 1'b0);
        check("rerr_eop", bus.r_error, exp_err);
        check("rcving_eop", bus.rcving, 1);

        bus.eop    = 1'b0;
        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
        tick();
        check("rcving_end", bus.rcving, 0);
        check("rerr_end", bus.r_error, exp_err);
        check("tclr_end", bus.timer_clear, 0);
        idle(3, 1'b0);

        n = wq.size();
        check("we_count", n, expq.size());
        for (int i = 0; i < n && i < expq.size(); i++) check("we_byte", wq[i], expq[i]);
    endtask

    initial begin
        int nb;
        int kk;

        total         = 0;
        bad           = 0;
        n_rst         = 1'b0;
        bus.d_edge    = 1'b0;
        bus.eop       = 1'b0;
        bus.en_sample = 1'b0;
        bus.rcv_data  = 8'h00;
        idle(3, 1'b0);
        check("rst_tclr", bus.timer_clear, 0);
        check("rst_rcving", bus.rcving, 0);
        check("rst_we", bus.w_enable, 0);
        check("rst_rerr", bus.r_error, 0);
        n_rst = 1'b1;
        idle(2, 1'b0);

        pkt_q = '{Sync, 8'hA5, 8'h3C};
        send_packet(0, 8);
        pkt_q = '{8'h81, 8'hA5};
        send_packet(0, 9);
        pkt_q = '{Sync, 8'h11};
        send_packet(3, 8);
        pkt_q = '{Sync, 8'h5A};
        send_packet(0, 10);

        // Reset in the middle of a data byte.
        wq.delete();
        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
        tick();
        for (int j = 0; j < 12; j++) begin
            idle(7, 1'b0);
            drive_bit(1'($urandom_range(0, 1)));
        end
        check("pre_rst_rcving", bus.rcving, 1);
        #2 n_rst = 1'b0;
        #1;
        check("arst_rcving", bus.rcving, 0);
        check("arst_tclr", bus.timer_clear, 0);
        check("arst_we", bus.w_enable, 0);
        check("arst_rerr", bus.r_error, 0);
        tick();
        n_rst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            idle(7, 1'b0);
            drive_bit(1'($urandom_range(0, 1)));
            check("idle_rcving", bus.rcving, 0);
            check("idle_tclr", bus.timer_clear, 0);
        end
        nb = wq.size();
        check("rst_no_write", nb, 0);

        pkt_q = '{Sync, 8'hC3, 8'h00, 8'hFF};
        send_packet(0, 8);
        pkt_q = '{Sync};
        send_packet(0, 8);
        pkt_q.delete();
        send_packet(0, 8);

        for (int p = 0; p < 20; p++) begin
            pkt_q.delete();
            nb = $urandom_range(1, 4);
            pkt_q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : Sync);
            for (int i = 1; i < nb; i++) pkt_q.push_back(8'($urandom));
            kk = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
            send_packet(kk, $urandom_range(8, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
